// File: rtl/calc_entry_ctrl_pkg.sv
// Shared key codes, operator encodings and FSM state encodings (state_dbg).
// No logic; decode helpers only.
// No flow control.
package calc_entry_ctrl_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQU = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    ST_N1_0 = 4'd0,
    ST_N1_1 = 4'd1,
    ST_N1_2 = 4'd2,
    ST_OPR  = 4'd3,
    ST_N2_1 = 4'd4,
    ST_N2_2 = 4'd5,
    ST_WAIT = 4'd6,
    ST_SHOW = 4'd7,
    ST_ERR  = 4'd8
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // Operator keys are contiguous starting at KEY_ADD, in op_t order.
  function automatic op_t key_to_op(input logic [3:0] k);
    logic [3:0] t;
    t = k - KEY_ADD;
    return op_t'(t[1:0]);
  endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Key decoder / ALU side signals of the calculator entry sequencer.
// master = key source and ALU, slave = entry controller.
// No flow control beyond the calc_start/calc_done handshake.
interface calc_entry_ctrl_if;
  import calc_entry_ctrl_pkg::*;

  logic       key_valid;
  logic [3:0] key_code;
  logic       calc_done;
  logic [3:0] dig_a;
  logic [3:0] dig_b;
  logic [3:0] dig_c;
  logic [3:0] dig_d;
  op_t        op;
  logic       calc_start;
  logic       busy;
  logic       result_valid;
  logic       err;
  logic [3:0] state_dbg;

  modport master (
    output key_valid, key_code, calc_done,
    input  dig_a, dig_b, dig_c, dig_d, op, calc_start, busy, result_valid, err, state_dbg
  );

  modport slave (
    input  key_valid, key_code, calc_done,
    output dig_a, dig_b, dig_c, dig_d, op, calc_start, busy, result_valid, err, state_dbg
  );

endinterface

// File: rtl/calc_entry_ctrl_timeout_cnt.sv
// ALU wait watchdog: counts cycles while en, expired on the last allowed cycle.
// expired is combinational from the count register (same cycle).
// No flow control; clr has priority over en.
module calc_timeout_cnt #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Count value TIMEOUT_CYC-1 is the last waiting cycle; the next edge would
  // make it TIMEOUT_CYC, which is when the wait is declared failed.
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear while idle, increment while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad entry sequencer: two 2-digit BCD operands + operator, ALU launch, clear/error handling.
// Key acted on at its edge, all outputs registered (visible next cycle).
// Keys other than CLR ignored while waiting on the ALU. CALC_AUTO_CLEAR_EN: digit in SHOW/ERR restarts entry.
module calc_entry_ctrl
  import calc_entry_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  calc_entry_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  op_t        op_q, op_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;
  logic       rv_q, rv_d;
  logic       err_q, err_d;

  logic [3:0] key;
  logic       key_dig, key_op, key_equ, key_clr;
  logic       to_clr, to_en, to_expired;

  assign key     = bus.key_code;
  assign key_dig = bus.key_valid && is_digit(key);
  assign key_op  = bus.key_valid && is_op(key);
  assign key_equ = bus.key_valid && (key == KEY_EQU);
  assign key_clr = bus.key_valid && (key == KEY_CLR);

  // Counter is held at zero outside WAIT so it starts from 0 on every entry.
  assign to_en  = (state_q == ST_WAIT);
  assign to_clr = !to_en;

  calc_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  // Next state, operand digits, operator and status flags.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    op_d    = op_q;

    if (key_clr) begin
      // CLR wins over everything, including a simultaneous calc_done.
      state_d = ST_N1_0;
      a_d     = '0;
      b_d     = '0;
      c_d     = '0;
      d_d     = '0;
      op_d    = OP_ADD;
    end else begin
      case (state_q)
        ST_N1_0: begin
          if (key_dig) begin
            a_d     = '0;
            b_d     = key;
            state_d = ST_N1_1;
          end else if (key_op) begin
            state_d = ST_ERR;
          end
        end
        ST_N1_1: begin
          if (key_dig) begin
            a_d     = b_q;
            b_d     = key;
            state_d = ST_N1_2;
          end else if (key_op) begin
            op_d    = key_to_op(key);
            state_d = ST_OPR;
          end
        end
        ST_N1_2: begin
          if (key_op) begin
            op_d    = key_to_op(key);
            state_d = ST_OPR;
          end
        end
        ST_OPR: begin
          if (key_dig) begin
            c_d     = '0;
            d_d     = key;
            state_d = ST_N2_1;
          end else if (key_op) begin
            op_d = key_to_op(key);
          end
        end
        ST_N2_1, ST_N2_2: begin
          if (key_dig && (state_q == ST_N2_1)) begin
            c_d     = d_q;
            d_d     = key;
            state_d = ST_N2_2;
          end else if (key_equ) begin
            if ((op_q == OP_DIV) && (c_q == 4'd0) && (d_q == 4'd0)) begin
              state_d = ST_ERR;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.calc_done) begin
            state_d = ST_SHOW;
          end else if (to_expired) begin
            state_d = ST_ERR;
          end
        end
        ST_SHOW, ST_ERR: begin
`ifdef CALC_AUTO_CLEAR_EN
          if (key_dig) begin
            a_d     = '0;
            b_d     = key;
            c_d     = '0;
            d_d     = '0;
            op_d    = OP_ADD;
            state_d = ST_N1_1;
          end
`endif
        end
        default: begin
          state_d = ST_N1_0;
        end
      endcase
    end

    // Flags follow the next state so they are registered alongside it.
    start_d = (state_d == ST_WAIT) && (state_q != ST_WAIT);
    busy_d  = (state_d == ST_WAIT);
    rv_d    = (state_d == ST_SHOW);
    err_d   = (state_d == ST_ERR);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_N1_0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      op_q    <= OP_ADD;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      op_q    <= op_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  assign bus.dig_a        = a_q;
  assign bus.dig_b        = b_q;
  assign bus.dig_c        = c_q;
  assign bus.dig_d        = d_q;
  assign bus.op           = op_q;
  assign bus.calc_start   = start_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = rv_q;
  assign bus.err          = err_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl: directed scenarios then random key/done traffic.
// Expected outputs come from a digit-list reference model, checked one cycle after each stimulus.
// Monitor runs on the falling edge, decoupled from the stimulus process.
module tb_calc_entry_ctrl;
  import calc_entry_ctrl_pkg::*;

  localparam int TCYC = 16;
  localparam int TOW  = 5;

  localparam int PH_ENTRY = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_SHOW  = 2;
  localparam int PH_ERR   = 3;

  typedef struct {
    int          cyc;
    logic [25:0] v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  calc_entry_ctrl_if bus();

  calc_entry_ctrl #(
    .TIMEOUT_CYC (TCYC),
    .TO_W        (TOW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- reference model ----------------
  logic [3:0] m_n1[$];
  logic [3:0] m_n2[$];
  int         m_phase;
  bit         m_has_op;
  logic [1:0] m_op;
  int         m_cnt;
  bit         m_start;
  exp_t       exp_q[$];

  task model_clear();
    m_n1.delete();
    m_n2.delete();
    m_phase  = PH_ENTRY;
    m_has_op = 0;
    m_op     = 2'd0;
    m_cnt    = 0;
    m_start  = 0;
  endtask

  task model_step(input bit kv, input logic [3:0] k, input bit dn);
    int t;
    int v;
    m_start = 0;
    if (kv && k == 4'd15) begin
      model_clear();
    end else begin
      case (m_phase)
        PH_ENTRY: begin
          if (kv) begin
            if (k <= 4'd9) begin
              if (!m_has_op) begin
                if (m_n1.size() < 2) m_n1.push_back(k);
              end else if (m_n2.size() < 2) begin
                m_n2.push_back(k);
              end
            end else if (k <= 4'd13) begin
              t = int'(k) - 10;
              if (!m_has_op) begin
                if (m_n1.size() == 0) begin
                  m_phase = PH_ERR;
                end else begin
                  m_has_op = 1;
                  m_op     = t[1:0];
                end
              end else if (m_n2.size() == 0) begin
                m_op = t[1:0];
              end
            end else if (k == 4'd14 && m_has_op && m_n2.size() > 0) begin
              v = 0;
              foreach (m_n2[i]) v = v * 10 + int'(m_n2[i]);
              if (m_op == 2'd3 && v == 0) begin
                m_phase = PH_ERR;
              end else begin
                m_phase = PH_WAIT;
                m_cnt   = 0;
                m_start = 1;
              end
            end
          end
        end
        PH_WAIT: begin
          if (dn) m_phase = PH_SHOW;
          else if (m_cnt == TCYC - 1) m_phase = PH_ERR;
          else m_cnt = m_cnt + 1;
        end
        default: begin
`ifdef CALC_AUTO_CLEAR_EN
          if (kv && k <= 4'd9) begin
            model_clear();
            m_n1.push_back(k);
          end
`endif
        end
      endcase
    end
  endtask

  function automatic logic [25:0] exp_out();
    logic [3:0] a, b, c, d, st;
    logic [1:0] op;
    a  = (m_n1.size() == 2) ? m_n1[0] : 4'd0;
    b  = (m_n1.size() > 0) ? m_n1[m_n1.size() - 1] : 4'd0;
    c  = (m_n2.size() == 2) ? m_n2[0] : 4'd0;
    d  = (m_n2.size() > 0) ? m_n2[m_n2.size() - 1] : 4'd0;
    op = m_has_op ? m_op : 2'd0;
    case (m_phase)
      PH_WAIT: st = ST_WAIT;
      PH_SHOW: st = ST_SHOW;
      PH_ERR:  st = ST_ERR;
      default: begin
        if (!m_has_op) st = (m_n1.size() == 0) ? ST_N1_0 : (m_n1.size() == 1) ? ST_N1_1 : ST_N1_2;
        else           st = (m_n2.size() == 0) ? ST_OPR  : (m_n2.size() == 1) ? ST_N2_1 : ST_N2_2;
      end
    endcase
    return {a, b, c, d, op, m_start, (m_phase == PH_WAIT), (m_phase == PH_SHOW),
            (m_phase == PH_ERR), st};
  endfunction

  // ---------------- monitor ----------------
  exp_t        mon_e;
  logic [25:0] mon_act;

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e   = exp_q.pop_front();
      mon_act = {bus.dig_a, bus.dig_b, bus.dig_c, bus.dig_d, bus.op, bus.calc_start,
                 bus.busy, bus.result_valid, bus.err, bus.state_dbg};
      n_checks = n_checks + 1;
      if (mon_act !== mon_e.v) begin
        n_fail = n_fail + 1;
        $display("FAIL outputs cyc=%0d actual abcd=%h op=%0d st/bz/rv/er=%b state=%0d required abcd=%h op=%0d st/bz/rv/er=%b state=%0d",
                 cyc, mon_act[25:10], mon_act[9:8], mon_act[7:4], mon_act[3:0],
                 mon_e.v[25:10], mon_e.v[9:8], mon_e.v[7:4], mon_e.v[3:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit kv, input logic [3:0] k, input bit dn);
    exp_t e;
    bus.key_valid = kv;
    bus.key_code  = k;
    bus.calc_done = dn;
    model_step(kv, k, dn);
    e.cyc = cyc + 1;
    e.v   = exp_out();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 4'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks = n_checks + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin
    int r;
    bit kv;
    logic [3:0] k;
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd5;
    bus.calc_done = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_dig_a", bus.dig_a, 4'd0);
    chk("reset_dig_b", bus.dig_b, 4'd0);
    chk("reset_dig_c", bus.dig_c, 4'd0);
    chk("reset_dig_d", bus.dig_d, 4'd0);
    chk("reset_op", {2'b00, bus.op}, 4'd0);
    chk("reset_flags", {bus.calc_start, bus.busy, bus.result_valid, bus.err}, 4'd0);
    chk("reset_state", bus.state_dbg, ST_N1_0);
    rst_n = 1'b1;

    // 42 + 7, done three cycles into WAIT, then a digit in SHOW
    send(1, 4'd4, 0); send(1, 4'd2, 0); send(1, KEY_ADD, 0); send(1, 4'd7, 0);
    send(1, KEY_EQU, 0);
    idle(2);
    send(0, 4'd0, 1);
    idle(1);
    send(1, 4'd8, 0);
    idle(1);
    send(1, KEY_CLR, 0);

    // third digit ignored, then divide by zero
    send(1, 4'd1, 0); send(1, 4'd2, 0); send(1, 4'd3, 0);
    send(1, KEY_DIV, 0); send(1, 4'd0, 0); send(1, KEY_EQU, 0);
    idle(2);
    send(1, KEY_CLR, 0);

    // ALU never answers: timeout
    send(1, 4'd5, 0); send(1, KEY_MUL, 0); send(1, 4'd9, 0); send(1, KEY_EQU, 0);
    idle(TCYC + 2);
    send(1, KEY_CLR, 0);

    // CLR and done on the same edge, late done ignored, operator in N1_0
    send(1, 4'd3, 0); send(1, KEY_SUB, 0); send(1, 4'd4, 0); send(1, KEY_EQU, 0);
    idle(1);
    send(1, KEY_CLR, 1);
    send(0, 4'd0, 1);
    idle(1);
    send(1, KEY_ADD, 0);
    idle(1);
    send(1, KEY_CLR, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      kv = ($urandom_range(0, 9) < 7);
      r  = $urandom_range(0, 99);
      if (r < 50)      k = 4'($urandom_range(0, 9));
      else if (r < 75) k = 4'($urandom_range(10, 13));
      else if (r < 93) k = KEY_EQU;
      else             k = KEY_CLR;
      send(kv, k, ($urandom_range(0, 9) == 0));
    end

    idle(2);
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
